pim_vector_ctrl: RTL and testbench
==================================

Name: pim_vector_ctrl

Overview:
- Compute-side sequencer sitting directly in front of one dual-port BRAM bank of the PIM array.
- Accepts a vector command, then for each element:
  - reads operand A through BRAM port A and operand B through BRAM port B;
  - applies the selected ALU op;
  - writes the result back through port A.
- Only the command whose bank id matches BANK_ID is executed.
- Drives the BRAM's wea/web/addra/addrb/dia/dib and consumes its registered doa/dob (1-cycle read latency).

Parameters:
- DATA_WIDTH, 16, element width; must match the BRAM.
- ADDR_WIDTH, 6, BRAM address width.
- SIZE, 5, bank-id width.
- BANK_ID, 0, id this controller answers to.

Ports:
- clk  in  1  rising-edge clock, shared with the BRAM
- rst_n  in  1  asynchronous active-low reset
- start  in  1  command strobe, sampled in IDLE only
- cmd_id  in  SIZE  target bank of the command
- opcode  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6 MAXU, 7 MINU
- src_a  in  ADDR_WIDTH  base address of operand vector A
- src_b  in  ADDR_WIDTH  base address of operand vector B
- dst  in  ADDR_WIDTH  base address of the result vector
- len  in  ADDR_WIDTH+1  element count, 0..2^ADDR_WIDTH
- busy  out  1  high from command accept until done
- done  out  1  one-cycle completion pulse
- wea  out  1  BRAM port A write enable
- web  out  1  BRAM port B write enable; held 0
- addra  out  ADDR_WIDTH  BRAM port A address
- addrb  out  ADDR_WIDTH  BRAM port B address
- dia  out  DATA_WIDTH  BRAM port A write data
- dib  out  DATA_WIDTH  BRAM port B write data; held 0
- doa  in  DATA_WIDTH  BRAM port A registered read data
- dob  in  DATA_WIDTH  BRAM port B registered read data

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE, element index i=0, latched command cleared.
  - busy=0, done=0, wea=web=0, addra=addrb=0, dia=dib=0.
  - Takes effect immediately, including mid-vector: no further writes occur, and already-written elements stay in the BRAM.
- FSM states IDLE, RD, EX, WR, DONE. BRAM-side outputs are a Moore decode of the state and datapath registers.
- IDLE:
  - If start=1 and cmd_id==BANK_ID, latch opcode, src_a, src_b, dst and len, set i=0 and busy=1.
  - Then go to DONE if len==0, otherwise go to RD.
  - If start=1 with a mismatched id, the command is ignored and nothing changes.
- RD: addra=src_a+i, addrb=src_b+i, wea=0. Next state is EX.
- EX:
  - doa/dob now hold the operands.
  - Register res = op(doa, dob), then go to WR.
- WR:
  - addra=dst+i, dia=res, wea=1 for exactly this cycle.
  - i increments; go to DONE if i+1==len, else go to RD.
- DONE: done=1 for one cycle, busy drops at the same edge, then return to IDLE.
- Throughput: 3 cycles per element. A command of length N completes N*3+1 cycles after accept (done high in cycle 3N+1); len=0 gives done 1 cycle after accept.
- Address arithmetic: base+i is taken modulo 2^ADDR_WIDTH, so vectors wrap past the top of the bank.
- Arithmetic:
  - Operands are unsigned.
  - ADD, SUB and MUL keep the low DATA_WIDTH bits (wrap-around).
  - MAXU and MINU use unsigned compare.
- Overlap: dst may alias src_a or src_b. Element i is written before element i+1 is read, so in-place ops (dst==src_a) are exact and shifted overlaps see updated data.
- start while busy: ignored, with no queueing. Command inputs need to be stable only in the accept cycle.
- Port B never writes, so there is no write-write collision inside the BRAM.

Optional Feature:
- Macro: PIM_SAT_EN.
- Defined:
  - ADD saturates to 2^DATA_WIDTH-1.
  - SUB clamps to 0 on underflow.
  - MUL saturates to 2^DATA_WIDTH-1 if the full product exceeds the maximum.
- Undefined: all three wrap modulo 2^DATA_WIDTH. The other ops are identical in both builds.

Test Plan:
1. Preload A[0..3]=1,2,3,4 at 0x00 and B[0..3]=10,20,30,40 at 0x10; ADD with dst=0x20, len=4, cmd_id=BANK_ID -> mem[0x20..0x23]=11,22,33,44; done pulses 13 cycles after accept; exactly 4 wea pulses.
2. Issue the same command with cmd_id=BANK_ID+1 -> busy stays 0, no wea, memory unchanged. Then issue len=0 -> done 1 cycle after accept, no wea.
3. A=0xFFFF, B=0x0002, one ADD and one MUL, each len=1:
   - without PIM_SAT_EN -> results 0x0001 and 0xFFFE;
   - with PIM_SAT_EN -> 0xFFFF for both;
   - SUB 0x0001-0x0002 -> 0xFFFF without the macro, 0x0000 with it.
4. src_a=62, src_b=30, dst=61, len=4, XOR -> reads at 62,63,0,1 and writes at 61,62,63,0 (wrap). Element 1 reads mem[63] after element 0 wrote mem[61] (no alias); the result matches the sequential model.
5. In-place: dst=src_a=0x08, len=8, SUB with B=1 -> each A[i] is decremented once. Then pulse start again while busy -> ignored, still 8 writes total.
6. Assert rst_n=0 in EX of element 2 of a len=6 run -> wea=0 and busy=0 immediately; mem holds results for elements 0-1 only; after release a fresh command runs correctly.

Source files
------------

// File: rtl/pim_vector_ctrl.sv
// Vector sequencer in front of one dual-port BRAM bank: read A/B, apply ALU op, write back via port A.
// Define PIM_SAT_EN to make ADD/MUL saturate and SUB clamp at zero instead of wrapping.
module pim_vector_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned SIZE       = 5,
  parameter int unsigned BANK_ID    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [SIZE-1:0]       cmd_id,
  input  logic [2:0]            opcode,
  input  logic [ADDR_WIDTH-1:0] src_a,
  input  logic [ADDR_WIDTH-1:0] src_b,
  input  logic [ADDR_WIDTH-1:0] dst,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  wea,
  output logic                  web,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] dia,
  output logic [DATA_WIDTH-1:0] dib,
  input  logic [DATA_WIDTH-1:0] doa,
  input  logic [DATA_WIDTH-1:0] dob
);

  localparam int unsigned LW = ADDR_WIDTH + 1;
  localparam int unsigned PW = 2 * DATA_WIDTH;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_MAXU = 3'd6;
  localparam logic [2:0] OP_MINU = 3'd7;

  typedef enum logic [2:0] {IDLE, RD, EX, WR, DONE} state_t;

  state_t                state;
  logic [2:0]            op_q;
  logic [ADDR_WIDTH-1:0] src_a_q;
  logic [ADDR_WIDTH-1:0] src_b_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [LW-1:0]         len_q;
  logic [LW-1:0]         i_q;
  logic [LW-1:0]         i_nxt_c;
  logic [DATA_WIDTH-1:0] res_c;

`ifdef PIM_SAT_EN
  logic [DATA_WIDTH:0] sum_c;
  logic [PW-1:0]       prod_c;
  assign sum_c  = {1'b0, doa} + {1'b0, dob};
  assign prod_c = PW'(doa) * PW'(dob);
`endif

  assign i_nxt_c = i_q + LW'(1);

  // Port B is read-only.
  assign web = 1'b0;
  assign dib = '0;

  // ALU on the registered BRAM read data, valid in EX.
  always_comb begin
    res_c = '0;
    case (op_q)
`ifdef PIM_SAT_EN
      OP_ADD:  res_c = sum_c[DATA_WIDTH] ? '1 : sum_c[DATA_WIDTH-1:0];
      OP_SUB:  res_c = (doa < dob) ? '0 : DATA_WIDTH'(doa - dob);
      OP_MUL:  res_c = (|prod_c[PW-1:DATA_WIDTH]) ? '1 : prod_c[DATA_WIDTH-1:0];
`else
      OP_ADD:  res_c = DATA_WIDTH'(doa + dob);
      OP_SUB:  res_c = DATA_WIDTH'(doa - dob);
      OP_MUL:  res_c = DATA_WIDTH'(doa * dob);
`endif
      OP_AND:  res_c = doa & dob;
      OP_OR:   res_c = doa | dob;
      OP_XOR:  res_c = doa ^ dob;
      OP_MAXU: res_c = (doa > dob) ? doa : dob;
      OP_MINU: res_c = (doa < dob) ? doa : dob;
      default: res_c = '0;
    endcase
  end

  // Sequencer; BRAM-side outputs are registered so they are valid throughout the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      i_q     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wea     <= 1'b0;
      addra   <= '0;
      addrb   <= '0;
      dia     <= '0;
    end else begin
      wea  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (cmd_id == SIZE'(BANK_ID))) begin
            op_q    <= opcode;
            src_a_q <= src_a;
            src_b_q <= src_b;
            dst_q   <= dst;
            len_q   <= len;
            i_q     <= '0;
            busy    <= 1'b1;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RD;
              addra <= src_a;
              addrb <= src_b;
            end
          end
        end
        RD: state <= EX;
        EX: begin
          state <= WR;
          wea   <= 1'b1;
          addra <= dst_q + ADDR_WIDTH'(i_q);
          dia   <= res_c;
        end
        WR: begin
          i_q <= i_nxt_c;
          if (i_nxt_c == len_q) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= RD;
            addra <= src_a_q + ADDR_WIDTH'(i_nxt_c);
            addrb <= src_b_q + ADDR_WIDTH'(i_nxt_c);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pim_vector_ctrl.sv
// Scoreboard bench for pim_vector_ctrl with a behavioural dual-port BRAM (1-cycle registered read).
module tb_pim_vector_ctrl;

  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 6;
  localparam int unsigned SZ   = 5;
  localparam int unsigned BANK = 0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [SZ-1:0] cmd_id = '0;
  logic [2:0]    opcode = '0;
  logic [AW-1:0] src_a = '0, src_b = '0, dst = '0;
  logic [AW:0]   len = '0;
  logic          busy, done, wea, web;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dia, dib, doa, dob;

  logic [DW-1:0] mem [64];
  logic [DW-1:0] model [64];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  typedef struct packed {logic [AW-1:0] addr; logic [DW-1:0] data;} wr_t;
  wr_t exp_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int wr_cnt = 0;

  pim_vector_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE(SZ), .BANK_ID(BANK)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd_id(cmd_id), .opcode(opcode),
    .src_a(src_a), .src_b(src_b), .dst(dst), .len(len), .busy(busy), .done(done),
    .wea(wea), .web(web), .addra(addra), .addrb(addrb), .dia(dia), .dib(dib),
    .doa(doa), .dob(dob)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wea) mem[addra] <= dia;
    else if (bd_we) mem[bd_addr] <= bd_data;
    doa <= mem[addra];
    dob <= mem[addrb];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] alu(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [31:0] w;
    case (op)
      3'd0: begin
        w = 32'(a) + 32'(b);
`ifdef PIM_SAT_EN
        if (w > 32'hFFFF) w = 32'hFFFF;
`endif
      end
      3'd1: begin
        w = 32'(a) - 32'(b);
`ifdef PIM_SAT_EN
        if (a < b) w = 0;
`endif
      end
      3'd2: w = 32'(a & b);
      3'd3: w = 32'(a | b);
      3'd4: w = 32'(a ^ b);
      3'd5: begin
        w = 32'(a) * 32'(b);
`ifdef PIM_SAT_EN
        if (w > 32'hFFFF) w = 32'hFFFF;
`endif
      end
      3'd6: w = (a > b) ? 32'(a) : 32'(b);
      default: w = (a < b) ? 32'(a) : 32'(b);
    endcase
    return w[DW-1:0];
  endfunction

  // Write monitor: every wea must match the head of the expected-write queue.
  always @(negedge clk) begin
    if (rst_n && wea) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(addra), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(addra), 32'(e.addr));
        check("wr_data", 32'(dia), 32'(e.data));
      end
    end
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    model[a] = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Sequential reference: element k is fully written before element k+1 is read.
  task automatic expect_writes(input logic [2:0] op, input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                               input logic [AW-1:0] d, input int n);
    for (int k = 0; k < n; k++) begin
      logic [AW-1:0] ai, bi, di;
      logic [DW-1:0] r;
      ai = sa + AW'(k); bi = sb + AW'(k); di = d + AW'(k);
      r = alu(op, model[ai], model[bi]);
      model[di] = r;
      exp_q.push_back('{addr: di, data: r});
    end
  endtask

  task automatic drive_cmd(input logic [SZ-1:0] id, input logic [2:0] op, input logic [AW-1:0] sa,
                           input logic [AW-1:0] sb, input logic [AW-1:0] d, input logic [AW:0] l);
    @(negedge clk);
    start = 1'b1; cmd_id = id; opcode = op; src_a = sa; src_b = sb; dst = d; len = l;
    @(negedge clk);
    start = 1'b0; cmd_id = '0; opcode = '0; src_a = '0; src_b = '0; dst = '0; len = '0;
  endtask

  task automatic run_cmd(input string tag, input logic [SZ-1:0] id, input logic [2:0] op,
                         input logic [AW-1:0] sa, input logic [AW-1:0] sb, input logic [AW-1:0] d,
                         input logic [AW:0] l, input bit poke);
    int cyc;
    int wr0;
    wr0 = wr_cnt;
    if (id == SZ'(BANK)) begin
      expect_writes(op, sa, sb, d, int'(l));
      drive_cmd(id, op, sa, sb, d, l);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      cyc = 1;
      while (!done && cyc < 400) begin
        @(negedge clk);
        cyc++;
        if (poke && cyc == 5) begin
          start = 1'b1; cmd_id = SZ'(BANK); opcode = 3'd0; src_a = 6'h30; src_b = 6'h30; dst = 6'h30; len = 7'd3;
        end
        if (poke && cyc == 6) start = 1'b0;
      end
      check({tag, "_done_lat"}, 32'(cyc), 32'(3 * int'(l) + 1));
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_busy_off"}, 32'(busy), 32'd0);
      check({tag, "_wr_cnt"}, 32'(wr_cnt - wr0), 32'(l));
      check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    end else begin
      bit busy_seen;
      bit done_seen;
      busy_seen = 1'b0; done_seen = 1'b0;
      drive_cmd(id, op, sa, sb, d, l);
      repeat (20) begin
        @(negedge clk);
        busy_seen |= busy;
        done_seen |= done;
      end
      check({tag, "_busy_seen"}, 32'(busy_seen), 32'd0);
      check({tag, "_done_seen"}, 32'(done_seen), 32'd0);
      check({tag, "_wr_cnt"}, 32'(wr_cnt - wr0), 32'd0);
    end
  endtask

  initial begin
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wea", 32'(wea), 32'd0);
    check("rst_web", 32'(web), 32'd0);
    check("rst_addra", 32'(addra), 32'd0);
    check("rst_addrb", 32'(addrb), 32'd0);
    check("rst_dia", 32'(dia), 32'd0);
    check("rst_dib", 32'(dib), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 64; k++) preload(AW'(k), DW'(k * 37 + 5));

    // 1: basic ADD
    for (int k = 0; k < 4; k++) begin
      preload(AW'(k), DW'(k + 1));
      preload(AW'(16 + k), DW'(10 * (k + 1)));
    end
    run_cmd("t1_add", SZ'(BANK), 3'd0, 6'h00, 6'h10, 6'h20, 7'd4, 1'b0);
    for (int k = 0; k < 4; k++) check($sformatf("t1_mem%0d", k), 32'(mem[32 + k]), 32'(11 * (k + 1)));

    // 2: foreign bank id is ignored, zero-length completes immediately
    run_cmd("t2_foreign", SZ'(BANK + 1), 3'd0, 6'h00, 6'h10, 6'h20, 7'd4, 1'b0);
    run_cmd("t2_len0", SZ'(BANK), 3'd0, 6'h00, 6'h10, 6'h20, 7'd0, 1'b0);

    // 3: wrap vs saturation corners
    preload(6'h28, 16'hFFFF);
    preload(6'h29, 16'h0002);
    preload(6'h2C, 16'h0001);
    preload(6'h2D, 16'h0002);
    run_cmd("t3_add", SZ'(BANK), 3'd0, 6'h28, 6'h29, 6'h2A, 7'd1, 1'b0);
    run_cmd("t3_mul", SZ'(BANK), 3'd5, 6'h28, 6'h29, 6'h2B, 7'd1, 1'b0);
    run_cmd("t3_sub", SZ'(BANK), 3'd1, 6'h2C, 6'h2D, 6'h2E, 7'd1, 1'b0);
`ifdef PIM_SAT_EN
    check("t3_add_val", 32'(mem[6'h2A]), 32'hFFFF);
    check("t3_mul_val", 32'(mem[6'h2B]), 32'hFFFF);
    check("t3_sub_val", 32'(mem[6'h2E]), 32'h0000);
`else
    check("t3_add_val", 32'(mem[6'h2A]), 32'h0001);
    check("t3_mul_val", 32'(mem[6'h2B]), 32'hFFFE);
    check("t3_sub_val", 32'(mem[6'h2E]), 32'hFFFF);
`endif

    // 4: address wrap past the top of the bank with overlapping vectors
    run_cmd("t4_xor", SZ'(BANK), 3'd4, 6'd62, 6'd30, 6'd61, 7'd4, 1'b0);

    // 5: in-place decrement, with a start pulse while busy
    for (int k = 0; k < 8; k++) preload(AW'(6'h30 + k), 16'h0001);
    run_cmd("t5_inplace", SZ'(BANK), 3'd1, 6'h08, 6'h30, 6'h08, 7'd8, 1'b1);
    run_cmd("t5_maxu", SZ'(BANK), 3'd6, 6'h00, 6'h08, 6'h18, 7'd3, 1'b0);
    run_cmd("t5_minu", SZ'(BANK), 3'd7, 6'h00, 6'h08, 6'h1B, 7'd3, 1'b0);
    run_cmd("t5_and", SZ'(BANK), 3'd2, 6'h08, 6'h10, 6'h24, 7'd2, 1'b0);
    run_cmd("t5_or", SZ'(BANK), 3'd3, 6'h08, 6'h10, 6'h26, 7'd2, 1'b0);

    // 6: asynchronous reset in EX of element 2 of a 6-element run
    expect_writes(3'd0, 6'h00, 6'h10, 6'h38, 2);
    drive_cmd(SZ'(BANK), 3'd0, 6'h00, 6'h10, 6'h38, 7'd6);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_wea_rst", 32'(wea), 32'd0);
    check("t6_busy_rst", 32'(busy), 32'd0);
    check("t6_writes_before_rst", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_cmd("t6_after", SZ'(BANK), 3'd6, 6'h00, 6'h10, 6'h3E, 7'd2, 1'b0);

    for (int k = 0; k < 64; k++) check($sformatf("mem%0d", k), 32'(mem[k]), 32'(model[k]));
    exp_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
